n64_poll_ctrl: RTL and testbench

Synthesizable host-side master for the N64 single-wire controller bus. It schedules polls, periodically or on demand, and drives the 0x01 status-request command open-drain. It then receives the 32-bit button/joystick response and presents it as registered outputs with a valid strobe. It sits between the board pad (pulled up externally) and user logic.

---
 rtl/n64_pkg.sv | 45 ++++
 rtl/n64_line_sync.sv | 30 +++
 rtl/n64_poll_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_n64_poll_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 controller-bus poll master.
// Symbol timings are in microseconds and scaled by CLKS_PER_US in the top.
package n64_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_LOW,
    S_TX_HIGH,
    S_RX_WAIT,
    S_RX_SAMPLE,
    S_RX_STOP,
    S_DONE
  } n64_state_e;

  localparam int T_SHORT  = 1;
  localparam int T_LONG   = 3;
  localparam int T_SAMPLE = 2;

  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam int         CMD_BITS   = 8;
  localparam int         RESP_BITS  = 32;

  // Bit positions within the 16-bit buttons word
  localparam int BTN_A     = 15;
  localparam int BTN_B     = 14;
  localparam int BTN_Z     = 13;
  localparam int BTN_START = 12;
  localparam int BTN_D_UP  = 11;
  localparam int BTN_D_DN  = 10;
  localparam int BTN_D_L   = 9;
  localparam int BTN_D_R   = 8;
  localparam int BTN_L     = 5;
  localparam int BTN_R     = 4;
  localparam int BTN_C_UP  = 3;
  localparam int BTN_C_DN  = 2;
  localparam int BTN_C_L   = 1;
  localparam int BTN_C_R   = 0;

  // Symbol value for TX index idx; the stop symbol (idx 8) uses the short low like a '1'
  function automatic logic cmd_bit(input logic [5:0] idx);
    if (idx < 6'(CMD_BITS)) return CMD_STATUS[3'd7 - idx[2:0]];
    return 1'b1;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the bus pad plus falling-edge detect.
// Resets to the idle-high level so no false edge appears on reset release.
module n64_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync_val,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_val = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/n64_poll_ctrl.sv
// Host-side N64 controller poll master: sends the status command open-drain,
// receives the 32-bit response and presents it as registered outputs.
//
// state       | meaning
// S_IDLE      | line released, waiting for poll_start or period expiry
// S_TX_LOW    | driving the low part of command symbol bit_cnt (8 = stop)
// S_TX_HIGH   | released part of command symbol bit_cnt
// S_RX_WAIT   | waiting for the falling edge of response bit bit_cnt
// S_RX_SAMPLE | counting to the mid-bit sample point
// S_RX_STOP   | waiting for stop-bit fall, then for the line to return high
// S_DONE      | one cycle: outputs latched, valid high
module n64_poll_ctrl
  import n64_pkg::*;
#(
  parameter int CLKS_PER_US    = 50,
  parameter int POLL_PERIOD_US = 16667,
  parameter int RX_TIMEOUT_US  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_en,
  input  logic        poll_start,
  inout  wire         n64_data,
  output logic        busy,
  output logic        valid,
  output logic        error,
  output logic [15:0] buttons,
  output logic [7:0]  joy_x,
  output logic [7:0]  joy_y
);

  localparam int TMR_W = $clog2(RX_TIMEOUT_US * CLKS_PER_US + 1);
  localparam int PER_W = $clog2(POLL_PERIOD_US * CLKS_PER_US);

  localparam logic [TMR_W-1:0] SHORT_LD = TMR_W'(T_SHORT * CLKS_PER_US - 1);
  localparam logic [TMR_W-1:0] LONG_LD  = TMR_W'(T_LONG * CLKS_PER_US - 1);
  // Edge-detect cycle already counts as the first of the sample delay
  localparam logic [TMR_W-1:0] SAMP_LD  = TMR_W'(T_SAMPLE * CLKS_PER_US - 2);
  localparam logic [TMR_W-1:0] TO_LD    = TMR_W'(RX_TIMEOUT_US * CLKS_PER_US - 1);
  localparam logic [PER_W-1:0] PER_LD   = PER_W'(POLL_PERIOD_US * CLKS_PER_US - 1);

  n64_state_e        state, state_nx;
  logic [TMR_W-1:0]  tmr, tmr_nx;
  logic [5:0]        bit_cnt, bit_nx, bit_inc;
  logic [31:0]       rx, rx_nx;
  logic              stop_fall, stop_nx;
  logic              timeout;
  logic              tc;
  logic [PER_W-1:0]  per_cnt;
  logic              per_exp;
  logic              trigger;
  logic              drive_low;
  logic              line_s;
  logic              line_fall;

  n64_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (n64_data),
    .sync_val (line_s),
    .fall     (line_fall)
  );

  assign n64_data = drive_low ? 1'b0 : 1'bz;
  assign busy     = (state != S_IDLE);
  assign tc       = (tmr == '0);
  assign bit_inc  = bit_cnt + 6'd1;
  assign per_exp  = poll_en && (per_cnt == '0);
  // A foreign driver holding the line low blocks new polls
  assign trigger  = (state == S_IDLE) && line_s && (poll_start || per_exp);

  always_comb begin
    state_nx = state;
    tmr_nx   = tc ? tmr : tmr - 1'b1;
    bit_nx   = bit_cnt;
    rx_nx    = rx;
    stop_nx  = stop_fall;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          state_nx = S_TX_LOW;
          bit_nx   = '0;
          tmr_nx   = cmd_bit(6'd0) ? SHORT_LD : LONG_LD;
        end
      end
      S_TX_LOW: begin
        if (tc) begin
          if (bit_cnt == 6'(CMD_BITS)) begin
            state_nx = S_RX_WAIT;
            bit_nx   = '0;
            tmr_nx   = TO_LD;
          end else begin
            state_nx = S_TX_HIGH;
            tmr_nx   = cmd_bit(bit_cnt) ? LONG_LD : SHORT_LD;
          end
        end
      end
      S_TX_HIGH: begin
        if (tc) begin
          state_nx = S_TX_LOW;
          bit_nx   = bit_inc;
          tmr_nx   = cmd_bit(bit_inc) ? SHORT_LD : LONG_LD;
        end
      end
      S_RX_WAIT: begin
        if (line_fall) begin
          state_nx = S_RX_SAMPLE;
          tmr_nx   = SAMP_LD;
        end else if (tc) begin
          timeout = 1'b1;
        end
      end
      S_RX_SAMPLE: begin
        if (tc) begin
          rx_nx   = {rx[30:0], line_s};
          bit_nx  = bit_inc;
          tmr_nx  = TO_LD;
          stop_nx = 1'b0;
          state_nx = (bit_inc < 6'(RESP_BITS)) ? S_RX_WAIT : S_RX_STOP;
        end
      end
      S_RX_STOP: begin
        if (!stop_fall) begin
          if (line_fall) begin
            stop_nx = 1'b1;
            tmr_nx  = TO_LD;
          end else if (tc) begin
            timeout = 1'b1;
          end
        end else if (line_s) begin
          state_nx = S_DONE;
        end else if (tc) begin
          timeout = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (timeout) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tmr       <= '0;
      bit_cnt   <= '0;
      rx        <= '0;
      stop_fall <= 1'b0;
      drive_low <= 1'b0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      bit_cnt   <= bit_nx;
      rx        <= rx_nx;
      stop_fall <= stop_nx;
      drive_low <= (state_nx == S_TX_LOW);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (!poll_en) begin
      per_cnt <= '0;
    end else if (trigger) begin
      per_cnt <= PER_LD;
    end else if (per_cnt != '0) begin
      per_cnt <= per_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      error   <= 1'b0;
      buttons <= '0;
      joy_x   <= '0;
      joy_y   <= '0;
    end else begin
      valid <= (state_nx == S_DONE);
      if (timeout) begin
        error <= 1'b1;
      end else if (state_nx == S_DONE) begin
        error   <= 1'b0;
        buttons <= rx[31:16];
        joy_x   <= rx[15:8];
        joy_y   <= rx[7:0];
      end
    end
  end

endmodule

// File: tb/tb_n64_poll_ctrl.sv
// Directed bench for n64_poll_ctrl with a behavioural controller responder
// on a pulled-up bus; polls are driven from a vector table.
module tb_n64_poll_ctrl;
  import n64_pkg::*;

  localparam int C   = 10;
  localparam int PER = 500 * C;

  typedef struct {
    logic [31:0] data;
    bit          present;
    bit          stop;
    logic [15:0] e_btn;
    logic [7:0]  e_jx;
    logic [7:0]  e_jy;
    bit          e_err;
    int          e_valid;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        poll_en;
  logic        poll_start;
  wire         n64_data;
  logic        busy;
  logic        valid;
  logic        error;
  logic [15:0] buttons;
  logic [7:0]  joy_x;
  logic [7:0]  joy_y;

  logic        resp_low;
  int          checks;
  int          errors;
  int          cyc;
  int          valid_cnt;
  int          low_cnt;
  int          pulses[$];
  int          rises[$];
  logic        busy_d;
  vec_t        vecs[6];

  pullup (n64_data);
  assign n64_data = resp_low ? 1'b0 : 1'bz;

  n64_poll_ctrl #(
    .CLKS_PER_US   (C),
    .POLL_PERIOD_US(500),
    .RX_TIMEOUT_US (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .poll_en   (poll_en),
    .poll_start(poll_start),
    .n64_data  (n64_data),
    .busy      (busy),
    .valid     (valid),
    .error     (error),
    .buttons   (buttons),
    .joy_x     (joy_x),
    .joy_y     (joy_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Widths of the low pulses the DUT itself drives, measured at the clock edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (n64_data === 1'b0 && !resp_low) begin
      low_cnt <= low_cnt + 1;
    end else if (low_cnt > 0) begin
      pulses.push_back(low_cnt);
      low_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    busy_d <= busy;
    if (busy && !busy_d) rises.push_back(cyc);
    if (valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic respond(input logic [31:0] d, input bit with_stop);
    int n = 0;
    while (pulses.size() < 9 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_saw_cmd", pulses.size() >= 9, 1);
    repeat (2 * C) @(negedge clk);
    for (int b = 31; b >= 0; b--) begin
      resp_low = 1'b1;
      repeat (d[b] ? C : 3 * C) @(negedge clk);
      resp_low = 1'b0;
      repeat (d[b] ? 3 * C : C) @(negedge clk);
    end
    if (with_stop) begin
      resp_low = 1'b1;
      repeat (2 * C) @(negedge clk);
      resp_low = 1'b0;
    end
  endtask

  task automatic run_vec(input int i);
    int n = 0;
    int bad = 0;
    int v0;
    pulses.delete();
    v0 = valid_cnt;
    @(negedge clk) poll_start = 1'b1;
    @(negedge clk) poll_start = 1'b0;
    chk("busy_start", busy, 1);
    if (vecs[i].present) respond(vecs[i].data, vecs[i].stop);
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_release", busy, 0);
    repeat (5) @(negedge clk);
    chk("tx_count", pulses.size(), 9);
    for (int k = 0; k < pulses.size() && k < 9; k++)
      if (pulses[k] != ((k < 7) ? 3 * C : C)) bad++;
    chk("tx_widths", bad, 0);
    chk("buttons", buttons, vecs[i].e_btn);
    chk("joy_x", joy_x, vecs[i].e_jx);
    chk("joy_y", joy_y, vecs[i].e_jy);
    chk("error", error, vecs[i].e_err);
    chk("valid_pulses", valid_cnt - v0, vecs[i].e_valid);
  endtask

  initial begin
    int n;
    int r3;
    vecs[0] = '{32'h9000_7F81, 1, 1, 16'h9000, 8'h7F, 8'h81, 0, 1};
    vecs[1] = '{32'h0000_0000, 0, 0, 16'h9000, 8'h7F, 8'h81, 1, 0};
    vecs[2] = '{32'h0000_0000, 1, 1, 16'h0000, 8'h00, 8'h00, 0, 1};
    vecs[3] = '{32'hFFFF_FFFF, 1, 1, 16'hFFFF, 8'hFF, 8'hFF, 0, 1};
    vecs[4] = '{32'h0F3C_01FE, 1, 0, 16'hFFFF, 8'hFF, 8'hFF, 1, 0};
    vecs[5] = '{32'hA5C3_9669, 1, 1, 16'hA5C3, 8'h96, 8'h69, 0, 1};

    checks = 0; errors = 0; cyc = 0; valid_cnt = 0; low_cnt = 0; busy_d = 1'b0;
    reset = 1'b1; poll_en = 1'b0; poll_start = 1'b0; resp_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {busy, valid, error, buttons, joy_x, joy_y}, 0);
    chk("reset_line", n64_data, 1);

    for (int i = 0; i < 6; i++) begin
      run_vec(i);
      if (i == 0) begin
        chk("btn_a", buttons[BTN_A], 1);
        chk("btn_start", buttons[BTN_START], 1);
      end
    end

    // Reset during the first long low of the command
    pulses.delete();
    @(negedge clk) poll_start = 1'b1;
    @(negedge clk) poll_start = 1'b0;
    repeat (15) @(negedge clk);
    chk("tx_driving_low", n64_data, 0);
    reset = 1'b1;
    #1;
    chk("reset_releases_line", n64_data, 1);
    chk("reset_clears_outputs", {busy, valid, error, buttons, joy_x, joy_y}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_vec(5);

    // Foreign driver holding the line low blocks a poll request
    resp_low = 1'b1;
    repeat (4) @(negedge clk);
    poll_start = 1'b1;
    @(negedge clk) poll_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("foreign_low_no_poll", busy, 0);
    resp_low = 1'b0;
    repeat (10) @(negedge clk);

    // Periodic polling, then poll_start coinciding with the period tick
    rises.delete();
    @(negedge clk) poll_en = 1'b1;
    n = 0;
    while (rises.size() < 3 && n < 16000) begin
      @(negedge clk);
      n++;
    end
    chk("periodic_polls", rises.size() >= 3, 1);
    if (rises.size() >= 3) begin
      chk("period_1", rises[1] - rises[0], PER);
      chk("period_2", rises[2] - rises[1], PER);
      r3 = rises[2] + PER;
      while (cyc < r3 - 1) @(negedge clk);
      poll_start = 1'b1;
      @(negedge clk) poll_start = 1'b0;
      while (cyc < r3 + 100) @(negedge clk);
      poll_start = 1'b1;
      @(negedge clk) poll_start = 1'b0;
      while (cyc < r3 + PER - 10) @(negedge clk);
      chk("one_poll_per_window", rises.size(), 4);
      if (rises.size() >= 4) chk("coincident_start", rises[3], r3);
      n = 0;
      while (rises.size() < 5 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("period_after_coincident", rises.size() >= 5, 1);
      if (rises.size() >= 5) chk("period_3", rises[4] - rises[3], PER);
    end
    poll_en = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
